// File: rtl/pu_scheduler_pkg.sv
// Shared types and helpers for the PU scheduler: FSM state encoding,
// default PU latency and the requester-id width function.
package pu_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

  localparam int PU_LAT_DEFAULT = 2;

  // Width of a requester index; never zero so a single requester still has an id bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pu_scheduler_rr_arbiter.sv
// rr_arbiter: one-hot grant over NREQ requesters. Round-robin with a pointer
// by default; lowest-index fixed priority when PU_SCHED_FIXED_PRIO_EN is defined.
module rr_arbiter
  import pu_scheduler_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IDW  = id_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);

`ifdef PU_SCHED_FIXED_PRIO_EN

  always_comb begin
    logic found;
    // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (en && req[i] && !found) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        gnt_id = IDW'(i);
      end
    end
  end

`else

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  // Search wraps from rr_ptr_q around to rr_ptr_q-1.
  always_comb begin
    logic found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (en && req[idx] && !found) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = IDW'(idx);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|gnt) rr_ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr_q <= '0;
    else      rr_ptr_q <= rr_ptr_d;
  end

`endif

endmodule

// File: rtl/pu_scheduler.sv
// pu_scheduler: arbitrates NREQ operand sets onto one shared PU and tracks
// in-flight issues to tag results. Optional macro: PU_SCHED_FIXED_PRIO_EN.
module pu_scheduler
  import pu_scheduler_pkg::*;
#(
  parameter  int XLEN   = 5,
  parameter  int NREQ   = 4,
  parameter  int PU_LAT = PU_LAT_DEFAULT,
  parameter  int CNTW   = 16,
  localparam int IDW    = id_width(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*4*XLEN-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   flush,
  output logic [XLEN-1:0]        pu_num1,
  output logic [XLEN-1:0]        pu_num2,
  output logic [XLEN-1:0]        pu_num3,
  output logic [XLEN-1:0]        pu_num4,
  input  logic [XLEN-1:0]        pu_result,
  output logic                   res_valid,
  output logic [IDW-1:0]         res_id,
  output logic [XLEN-1:0]        res_data,
  output logic                   flush_done,
  output logic                   busy,
  output logic [CNTW-1:0]        issue_cnt
);

  sched_state_e state_q, state_d;

  logic                     grant_en, xfer, any_req, pipe_empty;
  logic [NREQ-1:0]          gnt;
  logic [IDW-1:0]           gnt_id;
  logic [4*XLEN-1:0]        sel_set;
  logic [PU_LAT-1:0]        trk_vld_q, trk_vld_d;
  logic [PU_LAT-1:0][IDW-1:0] trk_id_q, trk_id_d;
  logic [CNTW-1:0]          issue_cnt_q, issue_cnt_d;

  assign any_req    = |req_valid;
  assign busy       = |trk_vld_q;
  assign pipe_empty = ~busy;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (grant_en),
    .req    (req_valid),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign xfer      = |gnt;
  assign req_ready = gnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (flush) state_d = DRAIN;
               else if (any_req) state_d = ISSUE;
      ISSUE:   if (flush) state_d = DRAIN;
               else if (!any_req && pipe_empty) state_d = IDLE;
      DRAIN:   if (pipe_empty && !flush) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grants are also held off while reset is asserted; flush always wins over a request.
  always_comb begin
    grant_en   = rst && !flush &&
                 ((state_q == ISSUE) || ((state_q == IDLE) && any_req));
    flush_done = (state_q == DRAIN) && pipe_empty && !flush;
  end

  // gnt is one-hot or zero, so OR-ing the masked slices selects the granted set.
  always_comb begin
    sel_set = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) sel_set = sel_set | req_data[i*4*XLEN +: 4*XLEN];
    end
  end

  assign pu_num1 = sel_set[0*XLEN +: XLEN];
  assign pu_num2 = sel_set[1*XLEN +: XLEN];
  assign pu_num3 = sel_set[2*XLEN +: XLEN];
  assign pu_num4 = sel_set[3*XLEN +: XLEN];

  always_comb begin
    trk_vld_d    = '0;
    trk_id_d     = '0;
    trk_vld_d[0] = xfer;
    trk_id_d[0]  = gnt_id;
    for (int i = 1; i < PU_LAT; i++) begin
      trk_vld_d[i] = trk_vld_q[i-1];
      trk_id_d[i]  = trk_id_q[i-1];
    end
    issue_cnt_d = issue_cnt_q + CNTW'(xfer);
  end

  // NOTE: the tracking array is reset as a whole so pre-reset issues never surface as results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trk_vld_q   <= '0;
      trk_id_q    <= '0;
      issue_cnt_q <= '0;
    end else begin
      trk_vld_q   <= trk_vld_d;
      trk_id_q    <= trk_id_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign res_valid = trk_vld_q[PU_LAT-1];
  assign res_id    = trk_id_q[PU_LAT-1];
  assign res_data  = pu_result;
  assign issue_cnt = issue_cnt_q;

endmodule
